axis_fifo_pkt: RTL
==================

# axis_fifo_pkt

Parametrised AXI-Stream shift-register FIFO with any depth from 4 to 256 words and a tlast sideband. It adds an almost-full flag and a packet counter. An optional store-and-forward packet mode holds output until a complete packet is buffered. It replaces the fixed 16/32-deep stream FIFOs on the TX/RX sample paths, where packet-aligned bursts must not be released partially.

## Interface
- WIDTH, 32: data width in bits.
- DEEP_BITS, 5: log2 of depth; legal 2..8; capacity DEPTH = 2^DEEP_BITS words.
- PACKET_MODE, 0: 0 = cut-through; 1 = store-and-forward on tlast.
- AFULL_LEVEL, DEPTH-4: fifo_afull asserts when the stored word count is >= this value; legal 1..DEPTH.

- clk  in  1  single clock; all logic on rising edge.
- axisrst  in  1  synchronous, active-high reset.
- axis_rx_tdata  in  WIDTH  write data.
- axis_rx_tlast  in  1  last word of packet.
- axis_rx_tvalid  in  1  write request.
- axis_rx_tready  out  1  FIFO can accept a word.
- axis_tx_tdata  out  WIDTH  head-of-FIFO data.
- axis_tx_tlast  out  1  head-of-FIFO tlast.
- axis_tx_tvalid  out  1  head word presentable.
- axis_tx_tready  in  1  consumer accepts.
- fifo_used  out  DEEP_BITS+1  stored word count, 0..DEPTH.
- fifo_empty  out  1  registered; 1 when the count is 0.
- fifo_afull  out  1  registered; count >= AFULL_LEVEL.
- pkt_count  out  DEEP_BITS+1  number of stored words with tlast=1.

## Operation
- Storage is a shift register of WIDTH+1 bits (tdata, tlast) and DEPTH entries.
  - A write shifts in at index 0.
  - The read index is count-1; the head is the oldest entry.
  - In simulation this is a generic array; in synthesis it maps to SRL primitives by depth (SRL16E for DEEP_BITS<=4, cascaded SRLC32E above).
- wr = axis_rx_tvalid & axis_rx_tready.
- rd = axis_tx_tvalid & axis_tx_tready.
- axis_rx_tready = (count != DEPTH). It does not depend on axis_tx_tready, so a full FIFO with a simultaneous read still refuses the write.
- Count update:
  - wr only: +1.
  - rd only: -1.
  - wr and rd together: unchanged; the head index is unchanged and the data shifts underneath it.
- pkt_count update:
  - +1 on wr with rx_tlast.
  - -1 on rd with tx_tlast.
  - both in the same cycle: unchanged.
  - It never exceeds count.
- axis_tx_tvalid:
  - PACKET_MODE=0: ~fifo_empty.
  - PACKET_MODE=1: ~fifo_empty & (pkt_count != 0 | count == DEPTH).
  - The full override is the oversize-packet escape: a packet longer than DEPTH drains cut-through rather than deadlocking. Once released, the head stays valid until the FIFO empties or pkt_count rules apply again; tvalid is never withdrawn without rd.
- axis_tx_tdata and axis_tx_tlast are combinational from the storage at the head index. Their value is don't-care while tvalid=0.

## Timing
- Reset values:
  - count = 0.
  - pkt_count = 0.
  - fifo_empty = 1.
  - fifo_afull = 0.
  - axis_tx_tvalid = 0.
  - axis_rx_tready = 1. It is 1 in the cycle axisrst is high, because reset clears the count to 0 (never full).
- Storage contents are not reset.
- Reset mid-operation discards all stored words at the next edge; a wr or rd in the reset cycle is ignored.
- Write-to-read latency is 1 cycle: a word written at edge N is on tx with tvalid=1 after edge N.
  - In packet mode, tvalid rises after the edge that writes the tlast word.
- fifo_empty and fifo_afull are registered from the next-count value, so they are coherent with fifo_used every cycle.
- Throughput is one word per cycle in both directions simultaneously at any fill level below DEPTH.
- The counter width DEEP_BITS+1 avoids wrap; count==DEPTH is reachable only via writes.

## Test plan
- Reset, then 8 words 0x1..0x8 with back-to-back wr and tready=0. Required:
  - fifo_used=8, pkt_count=0.
  - tx_tdata=0x1 valid one cycle after the first write (PACKET_MODE=0).
  - With tready=1, the output is 1..8 in order and fifo_empty=1 after the 8th read.
- DEEP_BITS=5, fill 32 words. Required:
  - rx_tready=0 at fifo_used=32.
  - fifo_afull=1 from fifo_used=28.
  - A write held in the same cycle as a read is refused; the next cycle accepts it.
- Continuous wr+rd with 1 word stored for 100 cycles. Required: fifo_used stays 1 and the data order is preserved.
- PACKET_MODE=1: write 5 words with tlast on the 5th. Required:
  - tx_tvalid=0 through 4 writes; 1 after the 5th.
  - pkt_count 1 then 0 after the tlast read.
- PACKET_MODE=1, DEEP_BITS=4: 20-word packet. Required:
  - tvalid asserts at fifo_used=16 with pkt_count=0.
  - All 20 words drain in order; there is no deadlock.
- Assert axisrst with 10 words stored and wr/rd active. Required: the next cycle shows fifo_used=0, pkt_count=0, tvalid=0, rx_tready=1.

Source files
------------

// File: rtl/axis_fifo_pkt_if.sv
// Stream and status bundle for axis_fifo_pkt.
// The slave modport is the FIFO's view and the master modport is the producer/consumer view.
interface axis_fifo_pkt_if #(
  parameter int WIDTH     = 32,
  parameter int DEEP_BITS = 5
);
  logic [WIDTH-1:0]   axis_rx_tdata;
  logic               axis_rx_tlast;
  logic               axis_rx_tvalid;
  logic               axis_rx_tready;
  logic [WIDTH-1:0]   axis_tx_tdata;
  logic               axis_tx_tlast;
  logic               axis_tx_tvalid;
  logic               axis_tx_tready;
  logic [DEEP_BITS:0] fifo_used;
  logic               fifo_empty;
  logic               fifo_afull;
  logic [DEEP_BITS:0] pkt_count;

  modport slave (
    input  axis_rx_tdata, axis_rx_tlast, axis_rx_tvalid, axis_tx_tready,
    output axis_rx_tready, axis_tx_tdata, axis_tx_tlast, axis_tx_tvalid,
    output fifo_used, fifo_empty, fifo_afull, pkt_count
  );

  modport master (
    output axis_rx_tdata, axis_rx_tlast, axis_rx_tvalid, axis_tx_tready,
    input  axis_rx_tready, axis_tx_tdata, axis_tx_tlast, axis_tx_tvalid,
    input  fifo_used, fifo_empty, fifo_afull, pkt_count
  );
endinterface

// File: rtl/axis_fifo_pkt.sv
// Shift-register AXI-Stream FIFO with tlast sideband, almost-full flag, packet counter
// and an optional store-and-forward mode that holds output until a whole packet is buffered.
module axis_fifo_pkt #(
  parameter int WIDTH       = 32,
  parameter int DEEP_BITS   = 5,
  parameter int PACKET_MODE = 0,
  parameter int AFULL_LEVEL = (1 << DEEP_BITS) - 4
) (
  input  logic            clk,
  input  logic            axisrst,
  axis_fifo_pkt_if.slave  fifo_if
);
  localparam int DEPTH = 1 << DEEP_BITS;
  localparam int CW    = DEEP_BITS + 1;
  localparam logic [CW-1:0]        DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0]        AFULL_CNT = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0]        CNT_ONE   = CW'(1);
  localparam logic [DEEP_BITS-1:0] IDX_ONE   = DEEP_BITS'(1);

  logic [WIDTH:0]        mem [DEPTH];
  logic [CW-1:0]         count_q, count_d;
  logic [CW-1:0]         pkt_q, pkt_d;
  logic                  empty_q, afull_q;
  logic                  wr, rd, rxReady, txValid;
  logic [DEEP_BITS-1:0]  headIdx;
  logic [WIDTH:0]        headWord;

  // Reset clears the count, so the FIFO is never full while axisrst is high.
  assign rxReady  = axisrst | (count_q != DEPTH_CNT);
  assign headIdx  = count_q[DEEP_BITS-1:0] - IDX_ONE;
  assign headWord = mem[headIdx];

  always_comb begin
    txValid = ~empty_q;
    if (PACKET_MODE != 0) begin
      // A full FIFO releases even without tlast so oversize packets cannot deadlock.
      txValid = ~empty_q & ((pkt_q != '0) | (count_q == DEPTH_CNT));
    end
  end

  assign wr = fifo_if.axis_rx_tvalid & rxReady;
  assign rd = txValid & fifo_if.axis_tx_tready;

  always_comb begin
    count_d = count_q;
    pkt_d   = pkt_q;
    case ({wr, rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    case ({wr & fifo_if.axis_rx_tlast, rd & headWord[WIDTH]})
      2'b10:   pkt_d = pkt_q + CNT_ONE;
      2'b01:   pkt_d = pkt_q - CNT_ONE;
      default: pkt_d = pkt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (axisrst) begin
      count_q <= '0;
      pkt_q   <= '0;
      empty_q <= 1'b1;
      afull_q <= 1'b0;
    end else begin
      count_q <= count_d;
      pkt_q   <= pkt_d;
      empty_q <= (count_d == '0);
      afull_q <= (count_d >= AFULL_CNT);
    end
  end

  // Unreset shift storage; a concurrent read keeps the head index and lets data slide under it.
  always_ff @(posedge clk) begin
    if (wr && !axisrst) begin
      mem[0] <= {fifo_if.axis_rx_tlast, fifo_if.axis_rx_tdata};
      for (int i = 1; i < DEPTH; i++) begin
        mem[i] <= mem[i-1];
      end
    end
  end

  assign fifo_if.axis_rx_tready = rxReady;
  assign fifo_if.axis_tx_tvalid = txValid;
  assign fifo_if.axis_tx_tdata  = headWord[WIDTH-1:0];
  assign fifo_if.axis_tx_tlast  = headWord[WIDTH];
  assign fifo_if.fifo_used      = count_q;
  assign fifo_if.fifo_empty     = empty_q;
  assign fifo_if.fifo_afull     = afull_q;
  assign fifo_if.pkt_count      = pkt_q;
endmodule
